fft_sched: RTL and testbench

Sequencing controller between the decode stage and the FFT engine. It turns decoded `fft_wr_en` sample writes into addressed sample-buffer writes, launches the FFT when a frame is full, and applies frequency configuration (`set_freq`) at frame boundaries. It also generates the pipeline stall for sample writes and `syn` (wait-for-FFT) instructions. It sits beside the register file, fed by decode outputs, and drives the FFT engine's sample port and start/done handshake.

---
 rtl/fft_sched.sv | 136 +++++++++++++
 tb/tb_fft_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sched.sv
// fft_sched: turns decoded sample writes into sample-buffer writes, launches the FFT on a full frame,
// applies set_freq at frame boundaries and generates decode stall. Define FFT_SCHED_DBUF_EN for a ping-pong buffer.
`timescale 1ns/1ps
module fft_sched #(
    parameter int DATAW = 32,
    parameter int FFT_N = 512,
    parameter int FREQW = 16,
    localparam int CW = $clog2(FFT_N),
`ifdef FFT_SCHED_DBUF_EN
    localparam int AW = CW + 1
`else
    localparam int AW = CW
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_wr_en,
    input  logic             set_freq,
    input  logic             syn,
    input  logic [DATAW-1:0] wr_data,
    input  logic             fft_done,
    output logic             stall,
    output logic             smp_wr_en,
    output logic [AW-1:0]    smp_addr,
    output logic [DATAW-1:0] smp_data,
    output logic             fft_start,
    output logic             fft_bank,
    output logic [FREQW-1:0] freq_active,
    output logic             busy
);

    typedef enum logic [1:0] {FILL, START, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [FREQW-1:0] freq_pend;
    logic             wr_stall;
    logic             syn_stall;
    logic             wr_acc;
    logic             frame_last;

    assign busy = (state != FILL);

`ifdef FFT_SCHED_DBUF_EN
    logic fill_bank;
    logic pending;

    // The other bank is always free unless a full frame is already waiting for the engine.
    assign wr_stall  = pending;
    assign syn_stall = busy || pending;
`else
    assign wr_stall  = busy;
    assign syn_stall = busy;
    assign fft_bank  = 1'b0;
`endif

    assign stall      = (fft_wr_en && wr_stall) || (syn && syn_stall);
    assign wr_acc     = fft_wr_en && !wr_stall;
    assign frame_last = wr_acc && (count == CW'(FFT_N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            freq_pend   <= '0;
            freq_active <= '0;
            fft_start   <= 1'b0;
            smp_wr_en   <= 1'b0;
            smp_addr    <= '0;
            smp_data    <= '0;
`ifdef FFT_SCHED_DBUF_EN
            fill_bank   <= 1'b0;
            pending     <= 1'b0;
            fft_bank    <= 1'b0;
`endif
        end else begin
            fft_start <= (state == START);
            smp_wr_en <= wr_acc;
            if (set_freq)
                freq_pend <= wr_data[FREQW-1:0];
            if (wr_acc) begin
                smp_data <= wr_data;
`ifdef FFT_SCHED_DBUF_EN
                smp_addr <= {fill_bank, count};
`else
                smp_addr <= count;
`endif
                // FFT_N is a power of two, so the counter wraps to 0 on the last sample.
                count <= count + CW'(1);
            end
`ifdef FFT_SCHED_DBUF_EN
            if (frame_last)
                fill_bank <= ~fill_bank;
`endif
            case (state)
                FILL: begin
                    if (frame_last) begin
                        state <= START;
`ifdef FFT_SCHED_DBUF_EN
                        fft_bank <= fill_bank;
`endif
                    end
                end
                START: begin
                    freq_active <= freq_pend;
                    state       <= RUN;
`ifdef FFT_SCHED_DBUF_EN
                    if (frame_last)
                        pending <= 1'b1;
`endif
                end
                RUN: begin
`ifdef FFT_SCHED_DBUF_EN
                    // A frame finishing in the same cycle as done is launched straight away.
                    if (fft_done) begin
                        if (pending || frame_last) begin
                            state    <= START;
                            fft_bank <= ~fft_bank;
                            pending  <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end else if (frame_last) begin
                        pending <= 1'b1;
                    end
`else
                    if (fft_done)
                        state <= FILL;
`endif
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched (FFT_N=4): frame-level reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_fft_sched;
    localparam int DATAW = 32;
    localparam int FFT_N = 4;
    localparam int FREQW = 16;
    localparam int CW    = 2;
`ifdef FFT_SCHED_DBUF_EN
    localparam int AW   = CW + 1;
    localparam bit DBUF = 1'b1;
`else
    localparam int AW   = CW;
    localparam bit DBUF = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             fft_wr_en;
    logic             set_freq;
    logic             syn;
    logic [DATAW-1:0] wr_data;
    logic             fft_done;
    logic             stall;
    logic             smp_wr_en;
    logic [AW-1:0]    smp_addr;
    logic [DATAW-1:0] smp_data;
    logic             fft_start;
    logic             fft_bank;
    logic [FREQW-1:0] freq_active;
    logic             busy;

    fft_sched #(.DATAW(DATAW), .FFT_N(FFT_N), .FREQW(FREQW)) dut (
        .clk(clk), .rst(rst), .fft_wr_en(fft_wr_en), .set_freq(set_freq), .syn(syn),
        .wr_data(wr_data), .fft_done(fft_done), .stall(stall), .smp_wr_en(smp_wr_en),
        .smp_addr(smp_addr), .smp_data(smp_data), .fft_start(fft_start), .fft_bank(fft_bank),
        .freq_active(freq_active), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame being filled and the FFT job, not the controller's states.
    logic             m_we;
    int               m_addr;
    logic [31:0]      m_data;
    logic             m_start;    // fft_start expected this cycle
    logic             m_sched;    // a launch is being prepared; pulse comes next cycle
    logic             m_busy;     // FFT owns a frame
    logic             m_running;  // launch pulse already seen for the current job
    logic [FREQW-1:0] m_fa;
    logic [FREQW-1:0] m_fp;
    int               m_cnt;
    logic             m_fill_bank;
    logic             m_pending;
    logic             m_fft_bank;

    task automatic model_reset();
        m_we = 1'b0; m_addr = 0; m_data = '0; m_start = 1'b0; m_sched = 1'b0;
        m_busy = 1'b0; m_running = 1'b0; m_fa = '0; m_fp = '0; m_cnt = 0;
        m_fill_bank = 1'b0; m_pending = 1'b0; m_fft_bank = 1'b0;
    endtask

    task automatic model_step();
        logic wr_block, acc, done_eff, complete, was_sched;
        wr_block  = DBUF ? m_pending : m_busy;
        acc       = fft_wr_en && !wr_block;
        done_eff  = fft_done && m_busy && (m_start || m_running);
        complete  = acc && (m_cnt == FFT_N - 1);
        was_sched = m_sched;
        m_running = (m_running || m_start) && !done_eff;
        m_start   = was_sched;
        if (was_sched) m_fa = m_fp;
        m_sched = 1'b0;
        if (set_freq) m_fp = wr_data[FREQW-1:0];
        m_we = acc;
        if (acc) begin
            m_addr = (m_fill_bank ? FFT_N : 0) + m_cnt;
            m_data = wr_data;
            m_cnt  = (m_cnt + 1) % FFT_N;
        end
        if (complete) begin
            if (m_busy) m_pending = 1'b1;
            else begin
                m_busy     = 1'b1;
                m_sched    = 1'b1;
                m_fft_bank = m_fill_bank;
            end
            if (DBUF) m_fill_bank = !m_fill_bank;
        end
        if (done_eff) begin
            if (m_pending) begin
                m_pending  = 1'b0;
                m_sched    = 1'b1;
                m_fft_bank = !m_fft_bank;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        logic exp_stall;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            exp_stall = (fft_wr_en && (DBUF ? m_pending : m_busy)) || (syn && (m_busy || m_pending));
            chk("cyc_smp_wr_en", 32'(smp_wr_en), 32'(m_we));
            if (m_we) begin
                chk("cyc_smp_addr", 32'(smp_addr), 32'(m_addr));
                chk("cyc_smp_data", smp_data, m_data);
            end
            chk("cyc_fft_start", 32'(fft_start), 32'(m_start));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_freq_active", 32'(freq_active), 32'(m_fa));
            chk("cyc_fft_bank", 32'(fft_bank), 32'(m_fft_bank));
            chk("cyc_stall", 32'(stall), 32'(exp_stall));
            if (!rst) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic sf, input logic sy, input logic [31:0] d, input logic dn);
        fft_wr_en = w; set_freq = sf; syn = sy; wr_data = d; fft_done = dn;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_smp_wr_en"}, 32'(smp_wr_en), 32'h0);
        chk({tag, "_smp_addr"}, 32'(smp_addr), 32'h0);
        chk({tag, "_fft_start"}, 32'(fft_start), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_freq_active"}, 32'(freq_active), 32'h0);
        chk({tag, "_fft_bank"}, 32'(fft_bank), 32'h0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Frequency set in FILL, then a full frame 0x11..0x44.
        drive(1'b0, 1'b1, 1'b0, 32'h00AB, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(17 * (i + 1)), 1'b0);
            tick();
            chk("f1_we", 32'(smp_wr_en), 32'h1);
            chk("f1_addr", 32'(smp_addr), 32'(i));
            chk("f1_data", smp_data, 32'(17 * (i + 1)));
            chk("f1_start", 32'(fft_start), 32'h0);
            chk("f1_busy", 32'(busy), 32'(i == 3));
        end
        idle();
        tick();
        chk("f1_launch", 32'(fft_start), 32'h1);
        chk("f1_freq", 32'(freq_active), 32'h00AB);
        chk("f1_busy_run", 32'(busy), 32'h1);

        // New frequency during RUN must not disturb the running FFT.
        drive(1'b0, 1'b1, 1'b0, 32'h00CD, 1'b0);
        tick();
        chk("f1_pulse_once", 32'(fft_start), 32'h0);
        chk("f1_freq_hold", 32'(freq_active), 32'h00AB);

        // syn waits through RUN; done arrives on the 6th cycle.
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0, j == 5);
            #1;
            chk("syn_stall", 32'(stall), 32'h1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk("syn_release", 32'(stall), 32'h0);
        chk("syn_busy_low", 32'(busy), 32'h0);
        chk("syn_freq_hold", 32'(freq_active), 32'h00AB);
        tick();

        // Second frame picks up 0x00CD at its launch.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(32'h55 + i), 1'b0);
            tick();
        end
`ifndef FFT_SCHED_DBUF_EN
        drive(1'b1, 1'b0, 1'b0, 32'h99, 1'b0);
        #1;
        chk("sb_stall_start", 32'(stall), 32'h1);
        tick();
        chk("f2_launch", 32'(fft_start), 32'h1);
        chk("f2_freq", 32'(freq_active), 32'h00CD);
        for (int j = 0; j < 2; j++) begin
            chk("sb_no_write", 32'(smp_wr_en), 32'h0);
            chk("sb_stall_run", 32'(stall), 32'h1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h99, 1'b1);
        #1;
        chk("sb_stall_done", 32'(stall), 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h99, 1'b0);
        #1;
        chk("sb_unstall", 32'(stall), 32'h0);
        chk("sb_busy_low", 32'(busy), 32'h0);
        tick();
        idle();
        chk("sb_write_we", 32'(smp_wr_en), 32'h1);
        chk("sb_write_addr", 32'(smp_addr), 32'h0);
        chk("sb_write_data", smp_data, 32'h99);
`else
        idle();
        tick();
        chk("f2_launch", 32'(fft_start), 32'h1);
        chk("f2_freq", 32'(freq_active), 32'h00CD);
        chk("f2_bank", 32'(fft_bank), 32'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h99, 1'b0);
        tick();
        idle();
        chk("db_write_addr", 32'(smp_addr), 32'h0);
`endif

        // fft_done while filling is ignored.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
        chk("idle_done_busy", 32'(busy), 32'h0);
        tick();
        chk("idle_done_start", 32'(fft_start), 32'h0);
        chk("idle_done_busy2", 32'(busy), 32'h0);

        // Reset after two samples of a frame.
        drive(1'b1, 1'b0, 1'b0, 32'hE1, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_fill");
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'hF1, 1'b0);
        tick();
        idle();
        chk("rst_fill_addr", 32'(smp_addr), 32'h0);
        chk("rst_fill_data", smp_data, 32'hF1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(32'hF1 + i), 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        chk("rst_run_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_run");
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h5A, 1'b0);
        tick();
        idle();
        chk("rst_run_addr", 32'(smp_addr), 32'h0);
        chk("rst_run_data", smp_data, 32'h5A);

`ifdef FFT_SCHED_DBUF_EN
        // Ping-pong: bank 1 fills while bank 0 is transformed.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(17 * (i + 1)), 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(32'hA1 + i), 1'b0);
            #1;
            chk("db_nostall", 32'(stall), 32'h0);
            tick();
            chk("db_addr", 32'(smp_addr), 32'(4 + i));
            chk("db_data", smp_data, 32'(32'hA1 + i));
        end
        drive(1'b1, 1'b0, 1'b0, 32'hA5, 1'b0);
        #1;
        chk("db_fifth_stall", 32'(stall), 32'h1);
        tick();
        chk("db_fifth_nowrite", 32'(smp_wr_en), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'hA5, 1'b1);
        #1;
        chk("db_stall_done", 32'(stall), 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'hA5, 1'b0);
        #1;
        chk("db_unstall", 32'(stall), 32'h0);
        chk("db_busy_start", 32'(busy), 32'h1);
        tick();
        idle();
        chk("db_launch", 32'(fft_start), 32'h1);
        chk("db_launch_bank", 32'(fft_bank), 32'h1);
        chk("db_a5_addr", 32'(smp_addr), 32'h0);
        chk("db_a5_data", smp_data, 32'hA5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
`endif
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
